// File: rtl/alu_cmd_issuer.sv
// Purpose : queue ALU commands, drive them one at a time onto the ALU from registers, return Result/Zero with a tag.
// Latency : push at edge k into an idle, empty block -> operands driven after k+1, rsp_valid_o after k+2; 1 rsp / 2 cycles.
// Backpr. : cmd_ready_o = command FIFO not full (registered occupancy only); a response is held in RESP until rsp_ready_i.
//
// Ports   : clk/reset (sync, active-low) | cmd_* valid/ready command channel (op, signed A/B, tag)
//           ALU_Operation_o/A_o/B_o registered ALU drive, ALU_Result_i/Zero_i combinational ALU return
//           rsp_* valid/ready response channel (result, zero, tag, err) | busy_o = FIFO not empty or FSM not IDLE
// Option  : define ALU_CMD_ISSUER_OPCHECK_EN to trap unsupported opcodes (0110-1111) instead of issuing them;
//           when undefined every opcode is issued unchanged and rsp_err_o is tied to 0.

// Small generic FIFO: show-ahead head on pop_dat, no pass-through, ready from registered count only.
module alu_cmd_issuer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign push_rdy = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && !empty;
  assign pop_dat  = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [31:0]      cmd_a_i,
  input  logic [31:0]      cmd_b_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic [3:0]       ALU_Operation_o,
  output logic [31:0]      A_o,
  output logic [31:0]      B_o,
  input  logic [31:0]      ALU_Result_i,
  input  logic             Zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic             rsp_zero_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             busy_o
);
  localparam int FW = 4 + 32 + 32 + TAG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_head;
  logic [3:0]       head_op;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [TAG_W-1:0] head_tag;
  logic             capture;
  logic             op_bad;
  logic             issue_err;
  logic [TAG_W-1:0] tag_q;

  alu_cmd_issuer_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (cmd_valid_i),
    .push_rdy (cmd_ready_o),
    .push_dat ({cmd_op_i, cmd_a_i, cmd_b_i, cmd_tag_i}),
    .pop_vld  (fifo_pop),
    .pop_dat  (fifo_head),
    .empty    (fifo_empty)
  );

  assign {head_op, head_a, head_b, head_tag} = fifo_head;

`ifdef ALU_CMD_ISSUER_OPCHECK_EN
  logic issue_err_q;
  logic rsp_err_q;

  assign op_bad    = (head_op > 4'd5);
  assign issue_err = issue_err_q;
  assign rsp_err_o = rsp_err_q;

  // Remember whether the command now in flight was trapped, so ISSUE can substitute the error response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_err_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (fifo_pop) begin
        issue_err_q <= op_bad;
      end
      if (capture) begin
        rsp_err_q <= issue_err_q;
      end
    end
  end
`else
  assign op_bad    = 1'b0;
  assign issue_err = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // ALU is combinational: its outputs reflect the registered operands this cycle.
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ALU_Operation_o <= '0;
      A_o             <= '0;
      B_o             <= '0;
      tag_q           <= '0;
      rsp_result_o    <= '0;
      rsp_zero_o      <= 1'b0;
      rsp_tag_o       <= '0;
    end else begin
      if (fifo_pop) begin
        tag_q <= head_tag;
        // A trapped opcode leaves the ALU inputs at their previous values.
        if (!op_bad) begin
          ALU_Operation_o <= head_op;
          A_o             <= head_a;
          B_o             <= head_b;
        end
      end
      if (capture) begin
        rsp_result_o <= issue_err ? 32'd0 : ALU_Result_i;
        rsp_zero_o   <= issue_err ? 1'b1  : Zero_i;
        rsp_tag_o    <= tag_q;
      end
    end
  end

  assign rsp_valid_o = (state == RESP);
  assign busy_o      = !fifo_empty || (state != IDLE);
endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [3:0]       cmd_op_i;
  logic [31:0]      cmd_a_i;
  logic [31:0]      cmd_b_i;
  logic [TAG_W-1:0] cmd_tag_i;
  logic [3:0]       ALU_Operation_o;
  logic [31:0]      A_o;
  logic [31:0]      B_o;
  logic [31:0]      ALU_Result_i;
  logic             Zero_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_result_o;
  logic             rsp_zero_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             rsp_err_o;
  logic             busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [31:0]      res;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  // Last command actually driven to the ALU, tracked from what the bench sent.
  logic [3:0]  last_op;
  logic [31:0] last_a;
  logic [31:0] last_b;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_op_i        (cmd_op_i),
    .cmd_a_i         (cmd_a_i),
    .cmd_b_i         (cmd_b_i),
    .cmd_tag_i       (cmd_tag_i),
    .ALU_Operation_o (ALU_Operation_o),
    .A_o             (A_o),
    .B_o             (B_o),
    .ALU_Result_i    (ALU_Result_i),
    .Zero_i          (Zero_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_result_o    (rsp_result_o),
    .rsp_zero_o      (rsp_zero_o),
    .rsp_tag_o       (rsp_tag_o),
    .rsp_err_o       (rsp_err_o),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unsupported opcodes yield A ^ ~B so they are distinguishable from a trapped response.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return {b[19:0], 12'h000};
      4'd3:    return a | b;
      4'd4:    return a << b[4:0];
      4'd5:    return a >> b[4:0];
      default: return a ^ ~b;
    endcase
  endfunction

  always_comb begin
    ALU_Result_i = alu_ref(ALU_Operation_o, A_o, B_o);
    Zero_i       = (ALU_Result_i == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Push one command then wait for its response with rsp_ready_i high; got=0 if either bound expires.
  task automatic send_and_get(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [TAG_W-1:0] tag, output bit got, output logic [31:0] r,
                              output logic z, output logic [TAG_W-1:0] t, output logic e,
                              output logic [3:0] op_seen);
    bit pushed = 0;
    got = 0; r = '0; z = 0; t = '0; e = 0; op_seen = '0;
    cmd_valid_i = 1; cmd_op_i = op; cmd_a_i = a; cmd_b_i = b; cmd_tag_i = tag;
    rsp_ready_i = 1;
    for (int n = 0; n < 20; n++) begin
      if (cmd_ready_o) begin
        tick();
        pushed = 1;
        break;
      end
      tick();
    end
    cmd_valid_i = 0;
    if (pushed) begin
      for (int n = 0; n < 20; n++) begin
        if (rsp_valid_o) begin
          got = 1; r = rsp_result_o; z = rsp_zero_o; t = rsp_tag_o; e = rsp_err_o;
          op_seen = ALU_Operation_o;
          tick();
          break;
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset = 0; cmd_valid_i = 0; cmd_op_i = 0; cmd_a_i = 0; cmd_b_i = 0; cmd_tag_i = 0; rsp_ready_i = 0;
    tick(); tick();
    total++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || rsp_err_o !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: valid=%b busy=%b err=%b, expected 0 0 0", rsp_valid_o, busy_o, rsp_err_o);
    end
    total++;
    if (ALU_Operation_o !== 4'd0 || A_o !== 32'd0 || B_o !== 32'd0 || rsp_result_o !== 32'd0 ||
        rsp_zero_o !== 1'b0 || rsp_tag_o !== '0) begin
      bad++; $display("FAIL reset_data: op=%h a=%h b=%h res=%h zero=%b tag=%h, expected all 0",
                      ALU_Operation_o, A_o, B_o, rsp_result_o, rsp_zero_o, rsp_tag_o);
    end
    reset = 1;
    tick();
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready: cmd_ready_o=%b, expected 1", cmd_ready_o);
    end
    last_op = 0; last_a = 0; last_b = 0;
  endtask

  task automatic test_single_add();
    rsp_ready_i = 1;
    cmd_valid_i = 1; cmd_op_i = 4'd0; cmd_a_i = 32'd5; cmd_b_i = 32'd7; cmd_tag_i = 4'd3;
    tick();            // edge k: push
    cmd_valid_i = 0;
    tick();            // edge k+1: operands driven
    total++;
    if (ALU_Operation_o !== 4'd0 || A_o !== 32'd5 || B_o !== 32'd7 || rsp_valid_o !== 1'b0) begin
      bad++; $display("FAIL add_issue: op=%h a=%0d b=%0d valid=%b, expected 0 5 7 0",
                      ALU_Operation_o, A_o, B_o, rsp_valid_o);
    end
    tick();            // edge k+2: response valid
    total++;
    if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd12 || rsp_zero_o !== 1'b0 ||
        rsp_tag_o !== 4'd3 || rsp_err_o !== 1'b0) begin
      bad++; $display("FAIL add_rsp: valid=%b res=%0d zero=%b tag=%0d err=%b, expected 1 12 0 3 0",
                      rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_tag_o, rsp_err_o);
    end
    tick();            // handshake, back to idle
    total++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL add_done: valid=%b busy=%b, expected 0 0", rsp_valid_o, busy_o);
    end
    last_op = 0; last_a = 5; last_b = 7;
  endtask

  task automatic test_sub_srli();
    bit got; logic [31:0] r; logic z, e; logic [TAG_W-1:0] t; logic [3:0] os;
    send_and_get(4'd1, 32'h12345678, 32'h12345678, 4'd9, got, r, z, t, e, os);
    total++;
    if (!got || r !== 32'd0 || z !== 1'b1 || t !== 4'd9) begin
      bad++; $display("FAIL sub_zero: got=%0d res=%h zero=%b tag=%0d, expected 1 0 1 9", got, r, z, t);
    end
    send_and_get(4'd5, 32'h80000000, 32'd31, 4'd10, got, r, z, t, e, os);
    total++;
    if (!got || r !== 32'd1 || z !== 1'b0 || t !== 4'd10) begin
      bad++; $display("FAIL srli: got=%0d res=%h zero=%b tag=%0d, expected 1 1 0 10", got, r, z, t);
    end
    last_op = 5; last_a = 32'h80000000; last_b = 31;
  endtask

  task automatic test_random_ops();
    bit got; logic [31:0] r, a, b, er; logic z, e; logic [TAG_W-1:0] t; logic [3:0] os, op;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 5));
      a  = $urandom;
      b  = (i == 3) ? a : $urandom;
      if (i == 3) op = 4'd1;
      er = alu_ref(op, a, b);
      send_and_get(op, a, b, 4'(i), got, r, z, t, e, os);
      total++;
      if (!got || r !== er || z !== (er == 32'd0) || t !== 4'(i) || e !== 1'b0) begin
        bad++; $display("FAIL rand_op%0d: op=%0d got=%0d res=%h zero=%b tag=%0d err=%b, expected res=%h zero=%b tag=%0d err=0",
                        i, op, got, r, z, t, e, er, (er == 32'd0), i);
      end
      last_op = op; last_a = a; last_b = b;
    end
  endtask

  // Full FIFO holds DEPTH queued commands plus the one held in RESP.
  task automatic test_backpressure_full();
    exp_t q[$];
    exp_t ex;
    logic [31:0] a, b;
    logic push_now;
    int got = 0;
    int last_cyc = -1;
    rsp_ready_i = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      a = $urandom; b = $urandom;
      cmd_valid_i = 1; cmd_op_i = 4'd0; cmd_a_i = a; cmd_b_i = b; cmd_tag_i = 4'(i);
      total++;
      if (cmd_ready_o !== 1'b1) begin
        bad++; $display("FAIL full_accept%0d: cmd_ready_o=%b, expected 1", i, cmd_ready_o);
      end
      ex.res = a + b; ex.zero = ((a + b) == 32'd0); ex.tag = 4'(i);
      q.push_back(ex);
      tick();
    end
    a = $urandom; b = $urandom;
    cmd_valid_i = 1; cmd_op_i = 4'd1; cmd_a_i = a; cmd_b_i = b; cmd_tag_i = 4'd5;
    ex.res = a - b; ex.zero = ((a - b) == 32'd0); ex.tag = 4'd5;
    q.push_back(ex);
    for (int n = 0; n < 4; n++) begin
      total++;
      if (rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd0 || rsp_result_o !== q[0].res || cmd_ready_o !== 1'b0) begin
        bad++; $display("FAIL full_hold%0d: valid=%b tag=%0d res=%h ready=%b, expected 1 0 %h 0",
                        n, rsp_valid_o, rsp_tag_o, rsp_result_o, cmd_ready_o, q[0].res);
      end
      tick();
    end
    rsp_ready_i = 1;
    for (int n = 0; n < 40 && got < 6; n++) begin
      push_now = cmd_valid_i && cmd_ready_o;
      if (rsp_valid_o) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL full_extra: unexpected response tag=%0d", rsp_tag_o);
        end else begin
          ex = q.pop_front();
          if (rsp_result_o !== ex.res || rsp_zero_o !== ex.zero || rsp_tag_o !== ex.tag) begin
            bad++; $display("FAIL full_rsp%0d: res=%h zero=%b tag=%0d, expected %h %b %0d",
                            got, rsp_result_o, rsp_zero_o, rsp_tag_o, ex.res, ex.zero, ex.tag);
          end
        end
        if (last_cyc >= 0) begin
          total++;
          if (cyc - last_cyc != 2) begin
            bad++; $display("FAIL full_rate: %0d cycles between responses, expected 2", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      tick();
      if (push_now) cmd_valid_i = 0;
    end
    cmd_valid_i = 0;
    total++;
    if (got != 6) begin
      bad++; $display("FAIL full_count: %0d responses, expected 6", got);
    end
    tick();
    last_op = 1; last_a = a; last_b = b;
  endtask

  task automatic test_wrap_random();
    exp_t q[$];
    exp_t ex;
    int next_push = 0;
    int got = 0;
    for (int n = 0; n < 400 && got < 20; n++) begin
      rsp_ready_i = 1'($urandom_range(0, 1));
      if (next_push < 20) begin
        cmd_valid_i = 1; cmd_op_i = 4'd3; cmd_a_i = 32'(next_push); cmd_b_i = 32'h100;
        cmd_tag_i = 4'(next_push % 16);
      end else begin
        cmd_valid_i = 0;
      end
      if (cmd_valid_i && cmd_ready_o) begin
        ex.res = 32'(next_push) | 32'h100; ex.zero = 1'b0; ex.tag = 4'(next_push % 16);
        q.push_back(ex);
        next_push++;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL wrap_extra: unexpected response tag=%0d", rsp_tag_o);
        end else begin
          ex = q.pop_front();
          if (rsp_result_o !== ex.res || rsp_zero_o !== ex.zero || rsp_tag_o !== ex.tag) begin
            bad++; $display("FAIL wrap_rsp%0d: res=%h zero=%b tag=%0d, expected %h %b %0d",
                            got, rsp_result_o, rsp_zero_o, rsp_tag_o, ex.res, ex.zero, ex.tag);
          end
        end
        got++;
      end
      tick();
    end
    cmd_valid_i = 0; rsp_ready_i = 1;
    total++;
    if (got != 20) begin
      bad++; $display("FAIL wrap_count: %0d responses, expected 20", got);
    end
    tick(); tick();
    last_op = 3; last_a = 19; last_b = 32'h100;
  endtask

  task automatic test_reset_mid();
    bit got; logic [31:0] r; logic z, e; logic [TAG_W-1:0] t; logic [3:0] os;
    int stale = 0;
    rsp_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid_i = 1; cmd_op_i = 4'd0; cmd_a_i = 32'(i + 1); cmd_b_i = 32'd1; cmd_tag_i = 4'(7 + i);
      tick();
    end
    cmd_valid_i = 0;
    total++;
    if (rsp_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      bad++; $display("FAIL rmid_pre: valid=%b busy=%b, expected 1 1", rsp_valid_o, busy_o);
    end
    reset = 0;
    tick();
    total++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1 ||
        rsp_result_o !== 32'd0 || rsp_tag_o !== '0 || A_o !== 32'd0) begin
      bad++; $display("FAIL rmid_reset: valid=%b busy=%b ready=%b res=%h tag=%0d a=%h, expected 0 0 1 0 0 0",
                      rsp_valid_o, busy_o, cmd_ready_o, rsp_result_o, rsp_tag_o, A_o);
    end
    reset = 1; rsp_ready_i = 1;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++; $display("FAIL rmid_stale: %0d cycles with valid/busy after reset, expected 0", stale);
    end
    send_and_get(4'd0, 32'd100, 32'hFFFFFFFF, 4'd2, got, r, z, t, e, os);
    total++;
    if (!got || r !== 32'd99 || z !== 1'b0 || t !== 4'd2) begin
      bad++; $display("FAIL rmid_fresh: got=%0d res=%0d zero=%b tag=%0d, expected 1 99 0 2", got, r, z, t);
    end
    last_op = 0; last_a = 100; last_b = 32'hFFFFFFFF;
  endtask

  task automatic test_opcheck();
    bit got; logic [31:0] r; logic z, e; logic [TAG_W-1:0] t; logic [3:0] os;
    logic [3:0] prev_op;
    logic [31:0] prev_a;
    prev_op = last_op; prev_a = last_a;
    send_and_get(4'b1010, 32'd9, 32'd9, 4'd12, got, r, z, t, e, os);
`ifdef ALU_CMD_ISSUER_OPCHECK_EN
    total++;
    if (!got || e !== 1'b1 || r !== 32'd0 || z !== 1'b1 || t !== 4'd12) begin
      bad++; $display("FAIL opchk_err: got=%0d err=%b res=%h zero=%b tag=%0d, expected 1 1 0 1 12", got, e, r, z, t);
    end
    total++;
    if (os !== prev_op || A_o !== prev_a) begin
      bad++; $display("FAIL opchk_hold: op=%h a=%h, expected %h %h", os, A_o, prev_op, prev_a);
    end
`else
    total++;
    if (!got || e !== 1'b0 || r !== alu_ref(4'b1010, 32'd9, 32'd9) || z !== 1'b0 || t !== 4'd12) begin
      bad++; $display("FAIL opchk_pass: got=%0d err=%b res=%h zero=%b tag=%0d, expected 1 0 %h 0 12",
                      got, e, r, z, t, alu_ref(4'b1010, 32'd9, 32'd9));
    end
    total++;
    if (os !== 4'b1010 || A_o !== 32'd9) begin
      bad++; $display("FAIL opchk_issue: op=%b a=%0d, expected 1010 9 (prev %h)", os, A_o, prev_op);
    end
`endif
    send_and_get(4'd3, 32'h0F0, 32'h00F, 4'd13, got, r, z, t, e, os);
    total++;
    if (!got || e !== 1'b0 || r !== 32'h0FF || os !== 4'd3) begin
      bad++; $display("FAIL opchk_after: got=%0d err=%b res=%h op=%h, expected 1 0 0ff 3", got, e, r, os);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_srli();
    test_random_ops();
    test_backpressure_full();
    test_wrap_random();
    test_reset_mid();
    test_opcheck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
